// File: rtl/dma_bus_pkg.sv
// Shared definitions for the DMA burst bus responder.
//   - dma_state_e : responder FSM states
//   - BURST_LEN_W : width of the burst length field (length minus 1)
//   - BE_ALL      : all four byte lanes enabled
//   - addr_hit()  : address-window decode for a size-aligned window of 2^addr_bits words
package dma_bus_pkg;

  localparam int unsigned BURST_LEN_W = 8;
  localparam logic [3:0]  BE_ALL      = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StFinish,
    StError
  } dma_state_e;

  // Compares the bits above the word index and byte offset.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned addr_bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (addr_bits + 2);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/dma_burst_slave_ram.sv
// Single-port synchronous word RAM, 2^AddrBits x 32, byte-lane write enables.
//   clk_i   : clock
//   req_i   : access strobe; a read updates rdata_o on the next edge
//   we_i    : 1 = write, 0 = read
//   be_i    : byte-lane enables for writes
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, 1-cycle latency, holds while no read is requested
module dma_burst_slave_ram #(
  parameter int unsigned AddrBits = 9
) (
  input  logic                clk_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic [AddrBits-1:0] addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o
);

  logic [31:0] mem_q [2**AddrBits];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dma_burst_slave_mem.sv
// Burst-bus responder serving single and burst reads/writes from an internal word memory.
// Outputs are zero whenever the block is not driving the shared wired-OR bus.
//   clock, reset        : clock, synchronous active-high reset
//   beginTransactionIn  : transaction start, address on addressDataIn
//   endTransactionIn    : end of write, or abort
//   readNotWriteIn      : 1 = read, 0 = write (with beginTransactionIn)
//   dataValidIn         : write data valid on addressDataIn
//   busyIn              : master cannot accept read data this cycle
//   addressDataIn       : multiplexed address / write data
//   byteEnablesIn       : write byte lanes
//   burstSizeIn         : burst length minus 1 (with beginTransactionIn)
//   addressDataOut      : read data
//   dataValidOut        : read data valid
//   endTransactionOut   : pulse after last read word, or with busErrorOut
//   busErrorOut         : error pulse (window crossing or write overrun)
// Build option: define DMA_BURST_SLAVE_WRAP_EN to let bursts wrap at the window end
// instead of raising a length error.
module dma_burst_slave_mem
  import dma_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   readNotWriteIn,
  input  logic                   dataValidIn,
  input  logic                   busyIn,
  input  logic [31:0]            addressDataIn,
  input  logic [3:0]             byteEnablesIn,
  input  logic [BURST_LEN_W-1:0] burstSizeIn,
  output logic [31:0]            addressDataOut,
  output logic                   dataValidOut,
  output logic                   endTransactionOut,
  output logic                   busErrorOut
);

  localparam int unsigned CntW = BURST_LEN_W + 1;

  dma_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [BURST_LEN_W-1:0] len_q, len_d;
  // iss_q counts RAM reads issued, cnt_q counts words consumed (read) or received (write).
  logic [CntW-1:0]      iss_q, iss_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // RAM output holds a word that has not yet been accepted by the master.
  logic                 rvalid_q, rvalid_d;

  logic                 hit;
  logic [ADDR_BITS-1:0] start_idx;
  logic                 len_err;
  logic                 stall;
  logic                 consume;
  logic                 overrun;

  logic                 ram_req;
  logic                 ram_we;
  logic [3:0]           ram_be;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [31:0]          ram_rdata;

  assign hit       = addr_hit(addressDataIn, BASE_ADDR, ADDR_BITS);
  assign start_idx = addressDataIn[ADDR_BITS+1:2];

`ifdef DMA_BURST_SLAVE_WRAP_EN
  assign len_err = 1'b0;
`else
  localparam int unsigned SumW = ((ADDR_BITS > BURST_LEN_W) ? ADDR_BITS : BURST_LEN_W) + 1;
  localparam logic [SumW-1:0] LastIdx = SumW'((2**ADDR_BITS) - 1);
  logic [SumW-1:0] end_idx;
  assign end_idx = SumW'(start_idx) + SumW'(burstSizeIn);
  assign len_err = end_idx > LastIdx;
`endif

  assign stall   = rvalid_q & busyIn;
  assign consume = rvalid_q & ~busyIn;
  assign overrun = cnt_q > {1'b0, len_q};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    iss_d    = iss_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    ram_req  = 1'b0;
    ram_we   = 1'b0;
    ram_be   = byteEnablesIn & BE_ALL;
    ram_addr = base_q + ADDR_BITS'(iss_q);

    unique case (state_q)
      StIdle: begin
        if (beginTransactionIn && hit) begin
          base_d   = start_idx;
          len_d    = burstSizeIn;
          iss_d    = '0;
          cnt_d    = '0;
          rvalid_d = 1'b0;
          if (len_err) begin
            state_d = StError;
          end else if (readNotWriteIn) begin
            state_d = StRead;
          end else begin
            state_d = StWrite;
          end
        end
      end

      StRead: begin
        if (endTransactionIn) begin
          state_d  = StIdle;
          rvalid_d = 1'b0;
        end else begin
          if (consume) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Prefetch the next word whenever the output is not stalled, so an
          // unstalled burst streams one word per cycle.
          if (!stall && (iss_q <= {1'b0, len_q})) begin
            ram_req = 1'b1;
            iss_d   = iss_q + 1'b1;
          end
          rvalid_d = stall | ram_req;
          if (consume && (cnt_q == {1'b0, len_q})) begin
            state_d = StFinish;
          end
        end
      end

      StWrite: begin
        ram_addr = base_q + ADDR_BITS'(cnt_q);
        if (dataValidIn && overrun) begin
          state_d = StError;
        end else begin
          if (dataValidIn) begin
            ram_req = 1'b1;
            ram_we  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
          if (endTransactionIn) begin
            state_d = StIdle;
          end
        end
      end

      StFinish, StError: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      iss_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      iss_q    <= iss_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  dma_burst_slave_ram #(
    .AddrBits(ADDR_BITS)
  ) u_ram (
    .clk_i  (clock),
    .req_i  (ram_req),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .addr_i (ram_addr),
    .wdata_i(addressDataIn),
    .rdata_o(ram_rdata)
  );

  // All outputs come from registered state, so they drop to zero the cycle after reset.
  assign dataValidOut      = (state_q == StRead) && rvalid_q;
  assign addressDataOut    = dataValidOut ? ram_rdata : 32'h0;
  assign endTransactionOut = (state_q == StFinish) || (state_q == StError);
  assign busErrorOut       = (state_q == StError);

endmodule
